// File: rtl/aes_decipher.sv
// Iterative AES inverse cipher (AES-128/192/256) that fetches one round key per request from external key RAM.
// Optional busy output when AES_DECIPHER_BUSY_EN is defined.
module aes_decipher (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [127:0] ciphertext,
   input  logic [3:0]   rounds_total,
   input  logic [127:0] key,
   input  logic         key_valid,
   output logic         key_req,
   output logic [3:0]   round_key_no,
   output logic [127:0] plaintext,
`ifdef AES_DECIPHER_BUSY_EN
   output logic         busy,
`endif
   output logic         en_o
);

   typedef enum logic {IDLE, WAIT_KEY} state_t;

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   b;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         b = s[127-8*i -: 8];
         // Byte value v lives at bits [8*(255-v)+7 -: 8] of the packed table.
         o[127-8*i -: 8] = INV_SBOX[{~b, 3'b111} -: 8];
      end
      return o;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // m is a 4-bit constant multiplier; each set bit selects a, 2a, 4a or 8a.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
         o[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
         o[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
         o[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
      end
      return o;
   endfunction

   state_t       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [3:0]   rkn_q, rkn_d;
   logic         key_req_q, key_req_d;
   logic [127:0] pt_q, pt_d;
   logic         en_o_q, en_o_d;
   logic [127:0] inv_sr_sb;

   assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(st_q));

   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      rnd_d     = rnd_q;
      rkn_d     = rkn_q;
      key_req_d = 1'b0;
      pt_d      = pt_q;
      en_o_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               st_d      = ciphertext;
               rnd_d     = rounds_total;
               rkn_d     = rounds_total;
               key_req_d = 1'b1;
               state_d   = WAIT_KEY;
            end
         end
         WAIT_KEY: begin
            if (key_valid) begin
               // Round 0 is tested first so a degenerate Nr of 0 still terminates.
               if (rkn_q == 4'd0) begin
                  pt_d    = inv_sr_sb ^ key;
                  en_o_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  if (rkn_q == rnd_q) st_d = st_q ^ key;
                  else                st_d = inv_mix_columns(inv_sr_sb ^ key);
                  rkn_d     = rkn_q - 4'd1;
                  key_req_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         st_q      <= '0;
         rnd_q     <= '0;
         rkn_q     <= '0;
         key_req_q <= 1'b0;
         pt_q      <= '0;
         en_o_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         st_q      <= st_d;
         rnd_q     <= rnd_d;
         rkn_q     <= rkn_d;
         key_req_q <= key_req_d;
         pt_q      <= pt_d;
         en_o_q    <= en_o_d;
      end
   end

   assign key_req      = key_req_q;
   assign round_key_no = rkn_q;
   assign plaintext    = pt_q;
   assign en_o         = en_o_q;
`ifdef AES_DECIPHER_BUSY_EN
   assign busy         = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_aes_decipher.sv
// Scoreboard bench for aes_decipher: models the pre-expanded key RAM and checks FIPS-197 vectors.
// Busy checks are compiled in when AES_DECIPHER_BUSY_EN is defined.
module tb_aes_decipher;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [127:0] ciphertext;
   logic [3:0]   rounds_total;
   logic [127:0] key;
   logic         key_valid;
   logic         key_req;
   logic [3:0]   round_key_no;
   logic [127:0] plaintext;
   logic         en_o;
`ifdef AES_DECIPHER_BUSY_EN
   logic         busy;
`endif

   always #5 clk = ~clk;

   aes_decipher dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .ciphertext   (ciphertext),
      .rounds_total (rounds_total),
      .key          (key),
      .key_valid    (key_valid),
      .key_req      (key_req),
      .round_key_no (round_key_no),
      .plaintext    (plaintext),
`ifdef AES_DECIPHER_BUSY_EN
      .busy         (busy),
`endif
      .en_o         (en_o)
   );

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEYALL = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   typedef struct {
      logic [127:0] pt;
      int           start;
      int           lat;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;
   int           exp_addr = 0;
   logic [7:0]   sbox [256];
   logic [127:0] rk [15];
   logic [127:0] key_ram;
   logic         kv1;

   // Key RAM model: one-cycle read plus output register, valid two edges after the request.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      key_ram   <= rk[round_key_no];
      key       <= key_ram;
      kv1       <= key_req;
      key_valid <= kv1;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic expand(input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nw;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nw; i++) begin
         if (i < nk) w[i] = KEYALL[255-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) t = subword(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Caller is at a negedge; the op is pushed once the accepting edge has passed.
   task automatic start(input logic [127:0] ct, input int nk);
      exp_t x;
      expand(nk);
      ciphertext   = ct;
      rounds_total = 4'(nk + 6);
      en           = 1'b1;
      @(posedge clk);
      #1;
      en       = 1'b0;
      x.pt     = PT;
      x.start  = cyc;
      x.lat    = 3 * (nk + 7);
      exp_q.push_back(x);
      exp_addr = nk + 6;
   endtask

   task automatic wait_done(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) return;
      end
      chk("timeout_done", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
   endtask

   task automatic wait_en_o(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (en_o) return;
      end
      chk("timeout_en_o", {127'd0, en_o}, 128'd1);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (en_o) begin
            if (exp_q.size() == 0) chk("spurious_en_o", 128'd1, 128'd0);
            else begin
               e = exp_q.pop_front();
               chk("plaintext", plaintext, e.pt);
               chk("latency", 128'(cyc - e.start), 128'(e.lat));
            end
         end
         if (key_req) begin
            chk("round_key_no", {124'd0, round_key_no}, 128'(exp_addr));
            exp_addr = exp_addr - 1;
         end
`ifdef AES_DECIPHER_BUSY_EN
         chk("busy", {127'd0, busy}, {127'd0, (exp_q.size() != 0) && !en_o});
`endif
      end
   end

   initial begin
      reset        = 1'b1;
      en           = 1'b0;
      ciphertext   = '0;
      rounds_total = 4'd10;
      build_sbox();
      expand(4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_key_req", {127'd0, key_req}, 128'd0);
      chk("rst_rkno", {124'd0, round_key_no}, 128'd0);
      chk("rst_pt", plaintext, 128'd0);
      chk("rst_en_o", {127'd0, en_o}, 128'd0);
`ifdef AES_DECIPHER_BUSY_EN
      chk("rst_busy", {127'd0, busy}, 128'd0);
`endif
      reset = 1'b0;

      // AES-128 single block
      @(negedge clk);
      start(CT128, 4);
      wait_done(60);
      repeat (3) @(negedge clk);
      chk("idle_rkno", {124'd0, round_key_no}, 128'd0);

      // en re-pulsed mid-op with a different block and Nr must be ignored
      @(negedge clk);
      start(CT128, 4);
      repeat (10) @(negedge clk);
      ciphertext   = CT256;
      rounds_total = 4'd14;
      en           = 1'b1;
      @(negedge clk);
      en = 1'b0;
      wait_done(60);
      repeat (5) @(negedge clk);
      chk("pt_hold", plaintext, PT);

      // Back-to-back: AES-128, then AES-256 and AES-192 launched in each en_o cycle
      @(negedge clk);
      start(CT128, 4);
      wait_en_o(60);
      start(CT256, 8);
      wait_en_o(80);
      start(CT192, 6);
      wait_done(80);

      // Reset mid-op aborts; a fresh op afterwards completes normally
      @(negedge clk);
      start(CT192, 6);
      repeat (15) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("abort_key_req", {127'd0, key_req}, 128'd0);
      chk("abort_rkno", {124'd0, round_key_no}, 128'd0);
      chk("abort_pt", plaintext, 128'd0);
      chk("abort_en_o", {127'd0, en_o}, 128'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      start(CT128, 4);
      wait_done(60);
      repeat (5) @(negedge clk);
      chk("sb_empty", 128'(exp_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
